seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the dividend and quotient width in bits.
REQ-002 The block SHALL have parameter M, default 4, giving the divisor and remainder width in bits; legal range 1 <= M <= N.
REQ-003 Port clk, input, 1: clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port start, input, 1: request a new division; sampled only when busy=0.
REQ-006 Port dividend, input, N: unsigned dividend; sampled on the accepted start.
REQ-007 Port divisor, input, M: unsigned divisor; sampled on the accepted start.
REQ-008 Port busy, output, 1: high while a division is in progress (RUN or DONE).
REQ-009 Port done, output, 1: single-cycle pulse marking quotient/remainder/dbz valid.
REQ-010 Port quotient, output, N: unsigned quotient.
REQ-011 Port remainder, output, M: unsigned remainder.
REQ-012 Port dbz, output, 1: divide-by-zero flag for the last completed operation.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE; busy = (state != IDLE); done = (state == DONE); both are registered-state decodes with no combinational path from inputs.
REQ-014 In IDLE with start=1 and divisor!=0, the block SHALL latch both operands, clear the partial remainder (M+1 bits internal), load bit counter = N, clear dbz, and go to RUN.
REQ-015 In IDLE with start=1 and divisor==0, the block SHALL go directly to DONE with quotient=all ones, remainder=all ones, dbz=1.
REQ-016 In RUN, each cycle SHALL perform one restoring step, MSB first: shift the partial remainder left and insert the next dividend bit; trial-subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1, else restore and set the bit to 0.
REQ-017 RUN SHALL last exactly N cycles (counter decrements each cycle), then go to DONE.
REQ-018 Latency: with start sampled in cycle 0, done SHALL be high in exactly cycle N+1 (cycle 1 for divide-by-zero), for one cycle only; DONE SHALL return to IDLE unconditionally.
REQ-019 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for every operand pair with divisor != 0.
REQ-020 quotient, remainder and dbz SHALL hold their last completed values from done until the next accepted start; intermediate values are not required to be hidden during RUN.
REQ-021 start while busy=1 (RUN or DONE) SHALL be ignored, with no effect on state, operands or outputs; a start in the cycle after done (IDLE) SHALL be accepted.
REQ-022 Operand inputs SHALL be don't-care except in the accepted-start cycle.

Reset
REQ-023 rst=1 at a clock edge SHALL force state IDLE, busy=0, done=0, quotient=0, remainder=0, dbz=0, counter=0, regardless of state, including mid-RUN and in DONE.
REQ-024 rst SHALL take priority over start in the same cycle; an operation aborted by reset SHALL produce no done pulse.

Verification
REQ-025 N=8, M=4: start with dividend=200, divisor=7 -> done in cycle 9, quotient=28, remainder=4, dbz=0.
REQ-026 dividend=255, divisor=1 -> quotient=255, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5; dividend=0, divisor=15 -> 0, 0.
REQ-027 dividend=100, divisor=0 -> done in cycle 1, quotient=8'hFF, remainder=4'hF, dbz=1; the next valid division clears dbz.
REQ-028 start with 200/7, then rst in cycle 4 -> all outputs 0 from the next cycle, no done pulse; a fresh 13/3 afterwards -> quotient=4, remainder=1.
REQ-029 start with 200/7, then start with 9/2 in cycles 3 and 9 -> both ignored, result 28 r 4; start with 9/2 in cycle 10 is accepted -> quotient=4, remainder=1 in cycle 19.
REQ-030 An exhaustive sweep of all 256x15 nonzero-divisor pairs checked against REQ-019, plus back-to-back starts, SHALL pass.

Source files
------------

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential restoring divider, one quotient bit per cycle,
//               MSB first. Divide-by-zero completes in one cycle with
//               all-ones results and the dbz flag set.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int N = 8,   // dividend / quotient width
  parameter int M = 4    // divisor / remainder width, 1 <= M <= N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         dbz
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  dvd_q,   dvd_d;   // dividend bits still to be consumed, MSB first
  logic [M-1:0]  dvs_q,   dvs_d;
  logic [N-1:0]  quo_q,   quo_d;
  logic [M:0]    rem_q,   rem_d;   // partial remainder, one guard bit wide
  logic          dbz_q,   dbz_d;

  logic          div_zero;
  logic [M+1:0]  shift_w;          // partial remainder shifted with next dividend bit
  logic          fits_w;           // trial subtraction is non-negative
  logic [M:0]    diff_w;

  assign div_zero = (divisor == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: RUN lasts exactly N cycles, DONE lasts one
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (start) state_d = div_zero ? C_DONE : C_RUN;
      C_RUN:   if (cnt_q == CW'(1)) state_d = C_DONE;
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Status outputs decoded purely from the registered state
  always_comb begin
    busy = (state_q != C_IDLE);
    done = (state_q == C_DONE);
  end

  // One restoring step: the shifted remainder is compared at full width so
  // the guard bit participates; the kept difference always fits M+1 bits
  always_comb begin
    shift_w = {rem_q, dvd_q[N-1]};
    fits_w  = (shift_w >= {2'b00, dvs_q});
    diff_w  = shift_w[M:0] - {1'b0, dvs_q};
  end

  // Datapath next values: load on accepted start, iterate in RUN, hold otherwise
  always_comb begin
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    case (state_q)
      C_IDLE: begin
        if (start) begin
          if (div_zero) begin
            quo_d = '1;
            rem_d = '1;
            dbz_d = 1'b1;
            cnt_d = '0;
          end else begin
            dvd_d = dividend;
            dvs_d = divisor;
            quo_d = '0;
            rem_d = '0;
            cnt_d = CW'(N);
            dbz_d = 1'b0;
          end
        end
      end
      C_RUN: begin
        dvd_d    = dvd_q << 1;
        quo_d    = quo_q << 1;
        quo_d[0] = fits_w;
        rem_d    = fits_w ? diff_w : shift_w[M:0];
        cnt_d    = cnt_q - CW'(1);
      end
      default: begin
      end
    endcase
  end

  // Datapath registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q[M-1:0];
  assign dbz       = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider (N=8, M=4)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  int checks;
  int failures;

  seq_divider #(.N(8), .M(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one start, wait for done, check latency/results, then step into
  // the IDLE cycle right after done so a following call is back-to-back.
  task automatic run_div(input string tag, input int a, input int b,
                         input int eq, input int er, input int edbz, input int elat);
    int lat;
    start    = 1'b1;
    dividend = 8'(a);
    divisor  = 4'(b);
    tick();
    start    = 1'b0;
    dividend = 8'hA5;
    divisor  = 4'h3;
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"},   32'(quotient),  eq);
    chk({tag, "_r"},   32'(remainder), er);
    chk({tag, "_dbz"}, 32'(dbz),       edbz);
    tick();
    chk({tag, "_pulse"}, 32'(done), 0);
    chk({tag, "_idle"},  32'(busy), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_q",    32'(quotient), 0);
    chk("rst_r",    32'(remainder), 0);
    chk("rst_dbz",  32'(dbz), 0);
    rst = 1'b0;
    tick();

    // basic operations and operand extremes
    run_div("d200_7",  200, 7,  28,  4, 0, 9);
    run_div("d255_1",  255, 1,  255, 0, 0, 9);
    run_div("d5_9",    5,   9,  0,   5, 0, 9);
    run_div("d0_15",   0,   15, 0,   0, 0, 9);
    run_div("d255_15", 255, 15, 17,  0, 0, 9);

    // divide by zero, then a valid division clears dbz
    run_div("dbz",     100, 0,  255, 15, 1, 1);
    run_div("d13_3",   13,  3,  4,   1,  0, 9);

    // reset in the middle of RUN aborts with no done pulse
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    tick();                       // cycle 1
    start = 1'b0;
    tick(); tick(); tick();       // cycle 4
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    start = 1'b1;                 // reset wins over start
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_q",    32'(quotient), 0);
    chk("abort_r",    32'(remainder), 0);
    chk("abort_dbz",  32'(dbz), 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    run_div("post_rst", 13, 3, 4, 1, 0, 9);

    // starts while busy are ignored; start right after done is accepted
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    tick();                       // cycle 1
    start = 1'b0;
    tick(); tick();               // cycle 3
    start = 1'b1; dividend = 8'd9; divisor = 4'd2;
    tick();                       // cycle 4
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();   // cycle 9
    chk("ign_done9", 32'(done), 1);
    chk("ign_q",     32'(quotient), 28);
    chk("ign_r",     32'(remainder), 4);
    start = 1'b1; dividend = 8'd9; divisor = 4'd2;
    tick();                       // cycle 10, start held and accepted here
    chk("ign_done10", 32'(done), 0);
    chk("ign_busy10", 32'(busy), 0);
    chk("ign_hold_q", 32'(quotient), 28);
    chk("ign_hold_r", 32'(remainder), 4);
    tick();                       // cycle 11
    start = 1'b0;
    chk("acc_busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) tick();   // cycle 19
    chk("acc_done19", 32'(done), 1);
    chk("acc_q",      32'(quotient), 4);
    chk("acc_r",      32'(remainder), 1);
    tick();

    // divide by zero back-to-back, then reset while in DONE
    run_div("dbz_b2b", 7, 0, 255, 15, 1, 1);
    start = 1'b1; dividend = 8'd1; divisor = 4'd0;
    tick();
    start = 1'b0;
    chk("dbz_done", 32'(done), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("done_rst_done", 32'(done), 0);
    chk("done_rst_q",    32'(quotient), 0);
    chk("done_rst_dbz",  32'(dbz), 0);
    tick();

    // exhaustive sweep, every start issued in the cycle right after done
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        start = 1'b1; dividend = 8'(a); divisor = 4'(b);
        tick();
        start = 1'b0;
        begin
          int lat;
          lat = 1;
          while (!done && lat < 40) begin
            tick();
            lat++;
          end
          if (lat != 9) chk("sweep_lat", lat, 9);
        end
        chk("sweep", {16'd0, quotient, 4'd0, remainder}, {16'd0, 8'(a / b), 4'd0, 4'(a % b)});
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
